// File: rtl/gray_sync_decoder_if.sv
// Bundle of the Gray-code input, error clear and the decoded outputs of gray_sync_decoder.
// master drives the Gray code and clear; slave is the decoder side.
interface gray_sync_decoder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
);
  logic [WIDTH-1:0] gray_in;
  logic             clr_err;
  logic             ready;
  logic [WIDTH-1:0] bin_out;
  logic             step_up;
  logic             step_dn;
  logic             step_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output gray_in,
    output clr_err,
    input  ready,
    input  bin_out,
    input  step_up,
    input  step_dn,
    input  step_err,
    input  err_count
  );

  modport slave (
    input  gray_in,
    input  clr_err,
    output ready,
    output bin_out,
    output step_up,
    output step_dn,
    output step_err,
    output err_count
  );
endinterface

// File: rtl/gray_sync_decoder.sv
// Synchronises an asynchronous Gray-coded bus, converts it to binary and classifies each change
// as a +1 step, a -1 step or an illegal jump, with a saturating error counter.
module gray_sync_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 8
) (
  input logic              clk,
  input logic              rst,
  gray_sync_decoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);
  localparam logic [CntW-1:0]  FillLast = CntW'(SYNC_STAGES - 1);
  localparam logic [WIDTH-1:0] DeltaUp  = WIDTH'(1);

  typedef enum logic [1:0] {
    StFill,
    StPrime,
    StTrack
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_sync;
  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.gray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_sync = sync_q[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits from i upwards.
  always_comb begin
    b_new = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      b_new[i] = ^(g_sync >> i);
    end
  end

  assign delta = b_new - prev_q;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    prev_d     = prev_q;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StFill: begin
        if (fill_cnt_q == FillLast) begin
          state_d = StPrime;
        end else begin
          fill_cnt_d = fill_cnt_q + CntW'(1);
        end
      end
      StPrime: begin
        prev_d  = b_new;
        state_d = StTrack;
      end
      StTrack: begin
        prev_d = b_new;
        if (delta == DeltaUp) begin
          up_d = 1'b1;
        end else if (delta == '1) begin
          dn_d = 1'b1;
        end else if (delta != '0) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // A clear coinciding with an error keeps that error counted.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_err) begin
      cnt_d = err_d ? ERR_W'(1) : '0;
    end else if (err_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
      prev_q     <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      prev_q     <= prev_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ready     = (state_q == StTrack);
  assign bus.bin_out   = prev_q;
  assign bus.step_up   = up_q;
  assign bus.step_dn   = dn_q;
  assign bus.step_err  = err_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder: table vectors plus sweep, saturation and reset
// sequences, with expected outputs queued at drive time and compared at the output latency.
module tb_gray_sync_decoder;

  localparam int unsigned W  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned EW = 8;

  typedef struct {
    logic [W-1:0]  gray;
    logic          clr;
    logic [W-1:0]  bin;
    logic          up;
    logic          dn;
    logic          err;
    logic [EW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gray_sync_decoder_if #(.WIDTH(W), .ERR_W(EW)) bus ();

  gray_sync_decoder #(
    .WIDTH      (W),
    .SYNC_STAGES(S),
    .ERR_W      (EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int up_seen, dn_seen, err_seen;
  logic [W-1:0]  model_prev;
  logic [EW-1:0] model_cnt;
  exp_t q[$];
  exp_t tbl[13];
  exp_t dummy;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
    for (int b = 0; b < 16; b++) begin
      if (to_gray(4'(b)) == g) return 4'(b);
    end
    return '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic make_exp(input logic [W-1:0] g, input logic clr, output exp_t e);
    logic [W-1:0] b;
    logic [W-1:0] d;
    b = from_gray(g);
    d = b - model_prev;
    e.gray = g;
    e.clr  = clr;
    e.bin  = b;
    e.up   = (d == 4'd1);
    e.dn   = (d == 4'hF);
    e.err  = (d != 4'd0) && !e.up && !e.dn;
    if (clr) model_cnt = e.err ? 8'd1 : 8'd0;
    else if (e.err && model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    e.cnt      = model_cnt;
    model_prev = b;
  endtask

  // One clock: optionally queue a new expectation, then compare the entry due at this edge.
  task automatic cycle(input bit push, input exp_t e);
    bit          pop_now;
    exp_t        r;
    logic [15:0] act;
    logic [15:0] expv;
    if (push) begin
      q.push_back(e);
      bus.gray_in = e.gray;
    end
    pop_now     = push ? (q.size() == 3) : (q.size() > 0);
    bus.clr_err = pop_now ? q[0].clr : 1'b0;
    @(posedge clk);
    #1;
    if (pop_now) begin
      r = q.pop_front();
      up_seen  += int'(bus.step_up);
      dn_seen  += int'(bus.step_dn);
      err_seen += int'(bus.step_err);
      act  = {bus.ready, bus.step_up, bus.step_dn, bus.step_err, bus.bin_out, bus.err_count};
      expv = {1'b1, r.up, r.dn, r.err, r.bin, r.cnt};
      check("track", 32'(act), 32'(expv));
    end
  endtask

  task automatic step(input logic [W-1:0] g, input logic clr);
    exp_t e;
    make_exp(g, clr, e);
    cycle(1'b1, e);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(to_gray(model_prev), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2; i++) cycle(1'b0, dummy);
    bus.clr_err = 1'b0;
  endtask

  task automatic clear_tally();
    up_seen  = 0;
    dn_seen  = 0;
    err_seen = 0;
  endtask

  task automatic do_reset(input logic [W-1:0] g);
    logic [W-1:0]  b;
    logic [15:0]   act;
    logic [15:0]   expv;
    exp_t          s;
    b           = from_gray(g);
    bus.gray_in = g;
    bus.clr_err = 1'b0;
    #1 rst = 1'b1;
    #1;
    act = {bus.ready, bus.step_up, bus.step_dn, bus.step_err, bus.bin_out, bus.err_count};
    check("reset_outs", 32'(act), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      act  = {bus.ready, bus.step_up, bus.step_dn, bus.step_err, bus.bin_out, bus.err_count};
      expv = {(e == 3), 3'b000, (e == 3) ? b : 4'd0, 8'd0};
      check("fill_prime", 32'(act), 32'(expv));
    end
    q.delete();
    model_prev = b;
    model_cnt  = '0;
    s = '{g, 1'b0, b, 1'b0, 1'b0, 1'b0, 8'd0};
    q.push_back(s);
    q.push_back(s);
  endtask

  initial begin
    tbl[0]  = '{4'b0111, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{4'b0101, 1'b0, 4'd6,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{4'b0111, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd1};
    tbl[4]  = '{4'b0100, 1'b0, 4'd7,  1'b0, 1'b0, 1'b1, 8'd2};
    tbl[5]  = '{4'b0100, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 8'd2};
    tbl[6]  = '{4'b0101, 1'b0, 4'd6,  1'b0, 1'b1, 1'b0, 8'd2};
    tbl[7]  = '{4'b1000, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[8]  = '{4'b0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'd3};
    tbl[9]  = '{4'b1000, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 8'd3};
    tbl[10] = '{4'b1000, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{4'b0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{4'b0100, 1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 8'd1};
    dummy   = '{4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd0};
    bus.gray_in = '0;
    bus.clr_err = 1'b0;
    clear_tally();

    #1;
    do_reset(4'b0110);

    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, tbl[i]);
      model_prev = tbl[i].bin;
      model_cnt  = tbl[i].cnt;
      hold(2);
    end

    // Forward sweep 1..15 then wrap to 0.
    step(to_gray(4'd0), 1'b0);
    hold(2);
    drain();
    clear_tally();
    for (int b = 1; b <= 16; b++) begin
      step(to_gray(4'(b)), 1'b0);
      hold(2);
    end
    drain();
    check("sweep_up_count", 32'(up_seen), 32'd16);
    check("sweep_other", 32'(dn_seen + err_seen), 32'd0);
    check("sweep_bin_end", 32'(bus.bin_out), 32'd0);

    // Reverse sweep 15..0, starting with the 0 -> 15 wrap.
    clear_tally();
    for (int k = 0; k < 16; k++) begin
      step(to_gray(4'(15 - k)), 1'b0);
      hold(2);
    end
    drain();
    check("sweep_dn_count", 32'(dn_seen), 32'd16);
    check("sweep_dn_other", 32'(up_seen + err_seen), 32'd0);

    // Back-to-back illegal jumps drive the counter into saturation.
    clear_tally();
    for (int i = 0; i < 300; i++) begin
      step(to_gray((i % 2 == 0) ? 4'd8 : 4'd0), 1'b0);
    end
    drain();
    check("err_pulses", 32'(err_seen), 32'd300);
    check("err_saturated", 32'(bus.err_count), 32'd255);

    step(to_gray(4'd8), 1'b1);
    hold(2);
    step(to_gray(4'd8), 1'b1);
    hold(2);
    drain();
    check("err_cleared", 32'(bus.err_count), 32'd0);

    // Streaming single steps, then reset lands mid-stream.
    for (int k = 0; k < 6; k++) step(to_gray(model_prev + 4'd1), 1'b0);
    check("stream_pulse", 32'(bus.step_up), 32'd1);
    do_reset(to_gray(model_prev));
    for (int k = 0; k < 3; k++) begin
      step(to_gray(model_prev + 4'd1), 1'b0);
      hold(1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
# gray_sync_decoder

Receive-side stage for Gray-coded values produced by the binary-to-Gray encoder, typically a pointer or position code crossing in from another clock domain or an external encoder. Synchronises the Gray bus into `clk`, converts it back to binary, and classifies each change as a step up, a step down or an illegal jump. Provides a registered binary value, single-cycle step pulses and a saturating error counter for the downstream logic.

## Interface
- `WIDTH`, 4: Gray/binary bus width; must be ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flop depth; must be ≥ 2.
- `ERR_W`, 8: error counter width.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `gray_in`  in  WIDTH  Gray-coded input; asynchronous to `clk`.
- `clr_err`  in  1  synchronous clear of `err_count`.
- `ready`  out  1  high once tracking; low during reset and fill.
- `bin_out`  out  WIDTH  registered binary value of the last synchronised code.
- `step_up`  out  1  one-cycle pulse; value advanced by +1 mod 2^WIDTH.
- `step_dn`  out  1  one-cycle pulse; value retreated by −1 mod 2^WIDTH.
- `step_err`  out  1  one-cycle pulse; any other nonzero change.
- `err_count`  out  ERR_W  saturating count of `step_err` events.

## Operation
- Synchroniser: a chain of SYNC_STAGES flops on `gray_in`. The last stage is `g_sync`, with no logic between stages.
- Conversion: `b_new[WIDTH-1] = g_sync[WIDTH-1]`; `b_new[i] = b_new[i+1] ^ g_sync[i]`. This is combinational from `g_sync`.
- `prev` register: holds the binary value of the last accepted code and drives `bin_out` directly.
- State machine:
  - FILL: entered from reset. A counter runs for SYNC_STAGES cycles after `rst` deasserts so the chain flushes.
  - PRIME: one cycle. Loads `prev <= b_new` with no pulses, then moves to TRACK.
  - TRACK: runs every cycle with `d = b_new − prev` (mod 2^WIDTH).
    - d = 0: no action.
    - d = 1: `step_up`.
    - d = all-ones: `step_dn`.
    - Any other d: `step_err` and `err_count` increments.
    - `prev <= b_new` in every case; `bin_out` always resynchronises to the new value, even on error.
  - There is no other exit from TRACK; only `rst` leaves it.
- `ready` = (state == TRACK).
- Pulses are mutually exclusive. At most one is high per cycle.
- Wrap-around: `prev` = 2^WIDTH−1 → `b_new` = 0 is `step_up`; 0 → 2^WIDTH−1 is `step_dn`.
- `err_count`:
  - Saturates at all-ones; further errors still pulse `step_err`.
  - `clr_err` alone: count becomes 0 next edge.
  - `clr_err` with `step_err` in the same cycle: count becomes 1, so the new error is not lost.
  - Not cleared by leaving FILL.
- Reset (asynchronous, any time including mid-stream):
  - All sync flops, `prev`, `bin_out` and `err_count` go to 0.
  - Pulses go to 0, `ready` to 0, state to FILL.
  - No pulses are emitted for the value present at reset release.

## Timing
- `gray_in` stable before edge n appears at `g_sync` after edge n+SYNC_STAGES−1.
- `bin_out` and the pulses update on edge n+SYNC_STAGES, giving a latency of SYNC_STAGES cycles (2 by default).
- After `rst` falls, the sequence is:
  - FILL occupies SYNC_STAGES cycles.
  - PRIME occupies 1 cycle.
  - `ready` rises on the following edge, SYNC_STAGES+1 edges after reset release.
  - Input changes during FILL/PRIME are absorbed silently.
- Back-to-back single-step changes, one per cycle, produce one pulse per cycle with none dropped.
- A multi-bit transition caught mid-change yields `step_err`. This is expected for non-Gray sources and is counted.

## Test plan
- Reset then `gray_in` = 0110 (binary 4): no pulses, `ready` rises 3 edges after reset release, `bin_out` = 4, `err_count` = 0.
- Sweep binary 0..15 as Gray, one code per 3 cycles: 15 `step_up` pulses, `bin_out` tracks 0..15 at 2-cycle latency; then 15 → 0 gives `step_up`, `bin_out` = 0.
- Reverse sweep 15..0 then 0 → 15: 16 `step_dn` pulses, no `step_err`.
- Jump Gray 0000 → 0100 (binary 0 → 7): one `step_err`, `err_count` = 1, `bin_out` = 7.
- Force 300 illegal jumps: `err_count` saturates at 255. Assert `clr_err` on the same cycle as an error: count = 1; `clr_err` alone: count = 0.
- Assert `rst` while `step_up` pulses are streaming: all outputs 0 immediately. Release: no pulse for the held value, tracking resumes after FILL+PRIME.
